// File: rtl/synth_ctrl_regfile.sv
// synth_ctrl_regfile: Avalon-MM control register file for the synth voice engine.
// Global parameters are written straight to live registers. Per-voice KEY/FREQ/AMP
// registers are double-buffered: software writes shadow copies, a COMMIT write arms
// a transfer, and the next SAMPLE_TICK copies every shadow into live at once.
// Reads are registered with a fixed one-cycle latency.
// Optional feature: define SYNTH_CTRL_IRQ_EN to add the commit-done irq flag / IRQ.
module synth_ctrl_regfile #(
  parameter int NUM_VOICES = 4,
  parameter int FREQ_W     = 7,
  parameter int AMP_W      = 16,
  parameter int ADDR_W     = 7
) (
  input  logic                         CLK,
  input  logic                         RESET,
  input  logic                         SAMPLE_TICK,
  input  logic [ADDR_W-1:0]            AVL_ADDR,
  input  logic [3:0]                   AVL_BYTE_EN,
  input  logic                         AVL_READ,
  input  logic                         AVL_WRITE,
  input  logic                         AVL_CS,
  input  logic [31:0]                  AVL_WRITEDATA,
  output logic [31:0]                  AVL_READDATA,
  output logic                         AVL_READDATAVALID,
  output logic [1:0]                   SHAPE1,
  output logic [1:0]                   SHAPE0,
  output logic [15:0]                  ATTACK,
  output logic [15:0]                  DECAY,
  output logic [15:0]                  SUSTAIN,
  output logic [15:0]                  RLEASE,
  output logic                         GLIDE_EN,
  output logic                         ARP_EN,
  output logic                         PingPongEn,
  output logic [24:0]                  GLIDE_RATE,
  output logic [15:0]                  ARP_TIME,
  output logic [NUM_VOICES-1:0]        KEY,
  output logic [NUM_VOICES-1:0]        KEY_ON,
  output logic [NUM_VOICES-1:0]        KEY_OFF,
  output logic [NUM_VOICES*FREQ_W-1:0] FREQ,
  output logic [NUM_VOICES*AMP_W-1:0]  AMP1,
  output logic [NUM_VOICES*AMP_W-1:0]  AMP0,
  output logic                         COMMIT_PENDING,
  output logic                         IRQ
);

  localparam int GW = ADDR_W - 3;

  localparam logic [ADDR_W-1:0] A_SHAPE1   = ADDR_W'(0),
                                A_SHAPE0   = ADDR_W'(1),
                                A_ATTACK   = ADDR_W'(2),
                                A_DECAY    = ADDR_W'(3),
                                A_SUSTAIN  = ADDR_W'(4),
                                A_RLEASE   = ADDR_W'(5),
                                A_GLIDE_EN = ADDR_W'(6),
                                A_GLIDE_RT = ADDR_W'(7),
                                A_ARP_EN   = ADDR_W'(8),
                                A_ARP_TIME = ADDR_W'(9),
                                A_PINGPONG = ADDR_W'(10),
                                A_COMMIT   = ADDR_W'(16),
                                A_STATUS   = ADDR_W'(17);

  // Voice registers live in 8-word groups; the low 3 address bits pick the voice
  localparam logic [GW-1:0] G_KEY  = GW'(4),
                            G_FREQ = GW'(5),
                            G_AMP1 = GW'(6),
                            G_AMP0 = GW'(7);

  logic                         wr_en;
  logic                         rd_en;
  logic                         commit_wr;
  logic                         transfer;
  logic [2:0]                   voice_idx;
  logic [GW-1:0]                addr_grp;
  logic [31:0]                  reg_value;
  logic                         irq_flag;
  logic [NUM_VOICES-1:0]        shadow_key;
  logic [NUM_VOICES*FREQ_W-1:0] shadow_freq;
  logic [NUM_VOICES*AMP_W-1:0]  shadow_amp1;
  logic [NUM_VOICES*AMP_W-1:0]  shadow_amp0;

  // Byte-lane merge of write data onto the currently stored (zero-extended) value
  function automatic logic [31:0] lane_merge(input logic [31:0] cur,
                                             input logic [31:0] wdata,
                                             input logic [3:0]  be);
    logic [31:0] res;
    res = cur;
    for (int b = 0; b < 4; b++) begin
      if (be[b]) res[8*b +: 8] = wdata[8*b +: 8];
    end
    return res;
  endfunction

  assign wr_en     = AVL_WRITE & AVL_CS;
  assign rd_en     = AVL_READ & AVL_CS;
  assign voice_idx = AVL_ADDR[2:0];
  assign addr_grp  = AVL_ADDR[ADDR_W-1:3];
  assign commit_wr = wr_en && (AVL_ADDR == A_COMMIT);
  assign transfer  = SAMPLE_TICK & COMMIT_PENDING;

`ifdef SYNTH_CTRL_IRQ_EN
  logic status_clr;
  assign status_clr = wr_en && (AVL_ADDR == A_STATUS) && AVL_BYTE_EN[0] && AVL_WRITEDATA[1];

  // Sticky commit-done flag; a transfer on the same edge outranks a software clear
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET)          irq_flag <= 1'b0;
    else if (transfer)   irq_flag <= 1'b1;
    else if (status_clr) irq_flag <= 1'b0;
  end

  assign IRQ = irq_flag;
`else
  assign irq_flag = 1'b0;
  assign IRQ      = 1'b0;
`endif

  // Current value at the bus address: live for globals, shadow for voices, 0 elsewhere
  always_comb begin
    reg_value = '0;
    case (AVL_ADDR)
      A_SHAPE1:   reg_value = 32'(SHAPE1);
      A_SHAPE0:   reg_value = 32'(SHAPE0);
      A_ATTACK:   reg_value = 32'(ATTACK);
      A_DECAY:    reg_value = 32'(DECAY);
      A_SUSTAIN:  reg_value = 32'(SUSTAIN);
      A_RLEASE:   reg_value = 32'(RLEASE);
      A_GLIDE_EN: reg_value = 32'(GLIDE_EN);
      A_GLIDE_RT: reg_value = 32'(GLIDE_RATE);
      A_ARP_EN:   reg_value = 32'(ARP_EN);
      A_ARP_TIME: reg_value = 32'(ARP_TIME);
      A_PINGPONG: reg_value = 32'(PingPongEn);
      A_STATUS:   reg_value = {30'b0, irq_flag, COMMIT_PENDING};
      default:    reg_value = '0;
    endcase
    for (int v = 0; v < NUM_VOICES; v++) begin
      if (voice_idx == 3'(v)) begin
        if (addr_grp == G_KEY)  reg_value = 32'(shadow_key[v]);
        if (addr_grp == G_FREQ) reg_value = 32'(shadow_freq[v*FREQ_W +: FREQ_W]);
        if (addr_grp == G_AMP1) reg_value = 32'(shadow_amp1[v*AMP_W +: AMP_W]);
        if (addr_grp == G_AMP0) reg_value = 32'(shadow_amp0[v*AMP_W +: AMP_W]);
      end
    end
  end

  // Global parameters take bus writes directly into the live outputs
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      SHAPE1     <= '0;
      SHAPE0     <= '0;
      ATTACK     <= '0;
      DECAY      <= '0;
      SUSTAIN    <= '0;
      RLEASE     <= '0;
      GLIDE_EN   <= 1'b0;
      GLIDE_RATE <= '0;
      ARP_EN     <= 1'b0;
      ARP_TIME   <= '0;
      PingPongEn <= 1'b0;
    end else if (wr_en) begin
      case (AVL_ADDR)
        A_SHAPE1:   SHAPE1     <= 2'(lane_merge(reg_value, AVL_WRITEDATA, AVL_BYTE_EN));
        A_SHAPE0:   SHAPE0     <= 2'(lane_merge(reg_value, AVL_WRITEDATA, AVL_BYTE_EN));
        A_ATTACK:   ATTACK     <= 16'(lane_merge(reg_value, AVL_WRITEDATA, AVL_BYTE_EN));
        A_DECAY:    DECAY      <= 16'(lane_merge(reg_value, AVL_WRITEDATA, AVL_BYTE_EN));
        A_SUSTAIN:  SUSTAIN    <= 16'(lane_merge(reg_value, AVL_WRITEDATA, AVL_BYTE_EN));
        A_RLEASE:   RLEASE     <= 16'(lane_merge(reg_value, AVL_WRITEDATA, AVL_BYTE_EN));
        A_GLIDE_EN: GLIDE_EN   <= 1'(lane_merge(reg_value, AVL_WRITEDATA, AVL_BYTE_EN));
        A_GLIDE_RT: GLIDE_RATE <= 25'(lane_merge(reg_value, AVL_WRITEDATA, AVL_BYTE_EN));
        A_ARP_EN:   ARP_EN     <= 1'(lane_merge(reg_value, AVL_WRITEDATA, AVL_BYTE_EN));
        A_ARP_TIME: ARP_TIME   <= 16'(lane_merge(reg_value, AVL_WRITEDATA, AVL_BYTE_EN));
        A_PINGPONG: PingPongEn <= 1'(lane_merge(reg_value, AVL_WRITEDATA, AVL_BYTE_EN));
        default: ;
      endcase
    end
  end

  // Shadow copies of the per-voice registers; voices beyond NUM_VOICES never match
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      shadow_key  <= '0;
      shadow_freq <= '0;
      shadow_amp1 <= '0;
      shadow_amp0 <= '0;
    end else if (wr_en) begin
      for (int v = 0; v < NUM_VOICES; v++) begin
        if (voice_idx == 3'(v)) begin
          case (addr_grp)
            G_KEY:  shadow_key[v] <= 1'(lane_merge(reg_value, AVL_WRITEDATA, AVL_BYTE_EN));
            G_FREQ: shadow_freq[v*FREQ_W +: FREQ_W] <=
                      FREQ_W'(lane_merge(reg_value, AVL_WRITEDATA, AVL_BYTE_EN));
            G_AMP1: shadow_amp1[v*AMP_W +: AMP_W] <=
                      AMP_W'(lane_merge(reg_value, AVL_WRITEDATA, AVL_BYTE_EN));
            G_AMP0: shadow_amp0[v*AMP_W +: AMP_W] <=
                      AMP_W'(lane_merge(reg_value, AVL_WRITEDATA, AVL_BYTE_EN));
            default: ;
          endcase
        end
      end
    end
  end

  // Pending arms on COMMIT and is consumed by the first tick seen while already armed
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET)         COMMIT_PENDING <= 1'b0;
    else if (transfer)  COMMIT_PENDING <= 1'b0;
    else if (commit_wr) COMMIT_PENDING <= 1'b1;
  end

  // Live voice state loads all shadows together; key edges become one-cycle strobes
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      KEY     <= '0;
      FREQ    <= '0;
      AMP1    <= '0;
      AMP0    <= '0;
      KEY_ON  <= '0;
      KEY_OFF <= '0;
    end else begin
      KEY_ON  <= transfer ? (shadow_key & ~KEY) : '0;
      KEY_OFF <= transfer ? (~shadow_key & KEY) : '0;
      if (transfer) begin
        KEY  <= shadow_key;
        FREQ <= shadow_freq;
        AMP1 <= shadow_amp1;
        AMP0 <= shadow_amp0;
      end
    end
  end

  // Registered read port; data is forced to 0 whenever VALID is low
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      AVL_READDATAVALID <= 1'b0;
      AVL_READDATA      <= '0;
    end else begin
      AVL_READDATAVALID <= rd_en;
      AVL_READDATA      <= rd_en ? reg_value : '0;
    end
  end

endmodule
